neptuno_joy_deserializer: RTL



---
 rtl/neptuno_joy_deserializer_if.sv | 27 ++
 rtl/neptuno_joy_deserializer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/neptuno_joy_deserializer_if.sv
// Pin bundle between the joystick deserializer and the 74HC165-style chain / core consumer.
// master = deserializer side, slave = chain/consumer side.
interface neptuno_joy_deserializer_if #(
   parameter int unsigned NBITS = 16
);
   logic             joy_data;
   logic             joy_clk;
   logic             joy_load_n;
   logic [NBITS-1:0] joy_state;
   logic             frame_strobe;

   modport master (
      input  joy_data,
      output joy_clk,
      output joy_load_n,
      output joy_state,
      output frame_strobe
   );

   modport slave (
      output joy_data,
      input  joy_clk,
      input  joy_load_n,
      input  joy_state,
      input  frame_strobe
   );
endinterface

// File: rtl/neptuno_joy_deserializer.sv
// Drives a 74HC165-style joystick chain (load, then NBITS shift clocks) and publishes
// an active-high, optionally two-frame-filtered button word with a per-frame strobe.
module neptuno_joy_deserializer #(
   parameter int unsigned CLKDIV = 8,
   parameter int unsigned NBITS  = 16,
   parameter bit          FILTER = 1'b1
) (
   input  logic                              clk,
   input  logic                              reset,
   neptuno_joy_deserializer_if.master        joy
);
   localparam int unsigned PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int unsigned BW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLKDIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      LOW  = 2'd2,
      HIGH = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [PW-1:0]    pre_q;
   logic [BW-1:0]    bit_q;
   logic [BW-1:0]    bit_d;
   logic [1:0]       sync_q;
   logic [NBITS-1:0] shreg_q;
   logic [NBITS-1:0] prev_q;
   logic             tick_c;
   logic             sample_c;
   logic             done_c;

   assign tick_c = (pre_q == PRE_LAST);

   // Phase prescaler: one tick every CLKDIV clocks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
      end else if (tick_c) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PW'(1);
      end
   end

   // Two-stage synchronizer; idles high (released buttons)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], joy.joy_data};
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
      end
   end

   // Next state; sampling happens on the LOW tick, just before joy_clk rises
   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      sample_c = 1'b0;
      done_c   = 1'b0;
      if (tick_c) begin
         case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
               state_d = LOW;
               bit_d   = '0;
            end
            LOW: begin
               state_d  = HIGH;
               sample_c = 1'b1;
            end
            HIGH: begin
               if (bit_q == BIT_LAST) begin
                  state_d = IDLE;
                  done_c  = 1'b1;
               end else begin
                  state_d = LOW;
                  bit_d   = bit_q + BW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Chain controls decoded from next state so they change on the same edge as the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         joy.joy_clk    <= 1'b0;
         joy.joy_load_n <= 1'b1;
      end else begin
         joy.joy_clk    <= (state_d == HIGH);
         joy.joy_load_n <= (state_d != LOAD);
      end
   end

   // Capture shifted bits, inverted to active-high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
      end else if (sample_c) begin
         shreg_q[bit_q] <= ~sync_q[1];
      end
   end

   // Frame completion: strobe and atomic word update, optionally requiring two agreeing frames
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         joy.joy_state    <= '0;
         joy.frame_strobe <= 1'b0;
         prev_q           <= '0;
      end else begin
         joy.frame_strobe <= done_c;
         if (done_c) begin
            prev_q <= shreg_q;
            if (!FILTER || (shreg_q == prev_q)) begin
               joy.joy_state <= shreg_q;
            end
         end
      end
   end
endmodule
